apb_regfile_bridge: RTL and testbench



---
 rtl/apb_regfile_bridge_pkg.sv | 20 ++
 rtl/apb_regfile_bridge_if.sv | 30 +++
 rtl/apb_addr_check.sv | 40 ++++
 rtl/apb_regfile_bridge.sv | 144 ++++++++++++++
 tb/tb_apb_regfile_bridge.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_regfile_bridge_pkg.sv
// Shared definitions for the APB-to-register-file bridge.
// The address-map constants are also consumed by the register-file generator.
package apb_regfile_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_RESP
    } state_e;

    // Highest mapped word and the unmapped word that the read port idles on.
    localparam logic [7:0] DEF_MAX_ADDR  = 8'h0E;
    localparam logic [7:0] DEF_PARK_ADDR = 8'hFF;

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_regfile_bridge_if.sv
// APB4 completer-side bus bundle for the register-file bridge.
interface apb_regfile_bridge_if #(
    parameter int PADDR_W = 12,
    parameter int DATA_W  = 32
);
    import apb_regfile_bridge_pkg::*;

    localparam int BE_W = be_w(DATA_W);

    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [PADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]   pwdata;
    logic [BE_W-1:0]     pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_addr_check.sv
// Combinational decode of an APB byte address into a register-file word
// address plus an error flag for misaligned, upper-bit or unmapped accesses.
module apb_addr_check
    import apb_regfile_bridge_pkg::*;
#(
    parameter int                PADDR_W  = 12,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEF_MAX_ADDR)
) (
    input  logic [PADDR_W-1:0] paddr_i,
    output logic [ADDR_W-1:0]  word_addr_o,
    output logic               err_o
);

    logic upper_nz;

    generate
        if (PADDR_W > ADDR_W + 2) begin : g_upper
            assign upper_nz = |paddr_i[PADDR_W-1:ADDR_W+2];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        word_addr_o = paddr_i[ADDR_W+1:2];
        err_o       = 1'b0;
        if (paddr_i[1:0] != 2'b00) begin
            err_o = 1'b1;
        end
        if (upper_nz) begin
            err_o = 1'b1;
        end
        if (paddr_i[ADDR_W+1:2] > MAX_ADDR) begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/apb_regfile_bridge.sv
// APB4 slave that turns each bus transfer into a single-cycle strobe on the
// register file's write or read port; the read port idles on PARK_ADDR.
module apb_regfile_bridge
    import apb_regfile_bridge_pkg::*;
#(
    parameter int                PADDR_W     = 12,
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = ADDR_W'(DEF_MAX_ADDR),
    parameter logic [ADDR_W-1:0] PARK_ADDR   = ADDR_W'(DEF_PARK_ADDR),
    parameter int                WAIT_STATES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    apb_regfile_bridge_if.slave       apb,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [be_w(DATA_W)-1:0]   wr_be,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rd_data
);

    localparam int BE_W  = be_w(DATA_W);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                write_q;
    logic                err_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [DATA_W-1:0]   prdata_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [BE_W-1:0]     wr_be_q;
    logic [ADDR_W-1:0]   rd_addr_q;

    logic [ADDR_W-1:0]   word_addr_d;
    logic                err_d;
    logic                setup_d;

    apb_addr_check #(
        .PADDR_W  (PADDR_W),
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR)
    ) u_addr_check (
        .paddr_i     (apb.paddr),
        .word_addr_o (word_addr_d),
        .err_o       (err_d)
    );

    assign setup_d = apb.psel && !apb.penable;

    // Strobes are registered at the setup edge so they are visible exactly
    // during the CMD cycle; the read address snaps back to PARK_ADDR after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
            rd_addr_q <= PARK_ADDR;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge state.
            wr_en_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            rd_addr_q <= PARK_ADDR;
            unique case (state_q)
                S_IDLE: begin
                    if (setup_d) begin
                        state_q <= S_CMD;
                        write_q <= apb.pwrite;
                        err_q   <= err_d;
                        if (apb.pwrite && !err_d && (apb.pstrb != '0)) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= word_addr_d;
                            wr_data_q <= apb.pwdata;
                            wr_be_q   <= apb.pstrb;
                        end
                        if (!apb.pwrite && !err_d) begin
                            rd_addr_q <= word_addr_d;
                        end
                    end
                end
                S_CMD: begin
                    if (!apb.psel) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (!write_q) begin
                            prdata_q <= err_q ? '0 : rd_data;
                        end
                        if (WAIT_STATES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= '0;
                        end else begin
                            state_q   <= S_RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_q;
                        end
                    end
                end
                S_WAIT: begin
                    if (!apb.psel) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(WAIT_STATES - 1)) begin
                        state_q   <= S_RESP;
                        cnt_q     <= '0;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_be       = wr_be_q;
    assign rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// Directed bench for apb_regfile_bridge: a zero-wait instance (index 0) and a
// two-wait-state instance (index 1), with a response scoreboard per transfer.
module tb_apb_regfile_bridge;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;

    logic [1:0]  psel, penable, pwrite;
    logic [11:0] paddr  [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pstrb  [2];

    logic [1:0]  pready_w, pslverr_w, wr_en_w;
    logic [31:0] prdata_w  [2];
    logic [7:0]  wr_addr_w [2];
    logic [31:0] wr_data_w [2];
    logic [3:0]  wr_be_w   [2];
    logic [7:0]  rd_addr_w [2];
    logic [31:0] rd_data_w [2];

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Register-file read model: only word 0x02 holds the marker pattern.
    function automatic logic [31:0] rf_model(input logic [7:0] a);
        return (a == 8'h02) ? 32'h1234_5678 : {24'hC0FFEE, a};
    endfunction

    apb_regfile_bridge_if #(.PADDR_W(12), .DATA_W(32)) bus0 ();
    apb_regfile_bridge_if #(.PADDR_W(12), .DATA_W(32)) bus1 ();

    assign bus0.psel    = psel[0];
    assign bus0.penable = penable[0];
    assign bus0.pwrite  = pwrite[0];
    assign bus0.paddr   = paddr[0];
    assign bus0.pwdata  = pwdata[0];
    assign bus0.pstrb   = pstrb[0];
    assign pready_w[0]  = bus0.pready;
    assign pslverr_w[0] = bus0.pslverr;
    assign prdata_w[0]  = bus0.prdata;

    assign bus1.psel    = psel[1];
    assign bus1.penable = penable[1];
    assign bus1.pwrite  = pwrite[1];
    assign bus1.paddr   = paddr[1];
    assign bus1.pwdata  = pwdata[1];
    assign bus1.pstrb   = pstrb[1];
    assign pready_w[1]  = bus1.pready;
    assign pslverr_w[1] = bus1.pslverr;
    assign prdata_w[1]  = bus1.prdata;

    assign rd_data_w[0] = rf_model(rd_addr_w[0]);
    assign rd_data_w[1] = rf_model(rd_addr_w[1]);

    apb_regfile_bridge #(
        .PADDR_W(12), .ADDR_W(8), .DATA_W(32),
        .MAX_ADDR(8'h0E), .PARK_ADDR(8'hFF), .WAIT_STATES(0)
    ) dut0 (
        .clk(clk), .rst(rst), .apb(bus0),
        .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
        .wr_be(wr_be_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0])
    );

    apb_regfile_bridge #(
        .PADDR_W(12), .ADDR_W(8), .DATA_W(32),
        .MAX_ADDR(8'h0E), .PARK_ADDR(8'hFF), .WAIT_STATES(2)
    ) dut1 (
        .clk(clk), .rst(rst), .apb(bus1),
        .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
        .wr_be(wr_be_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input int d, input string tag);
        check({tag, "_pready"},  32'(pready_w[d]),  32'h0);
        check({tag, "_pslverr"}, 32'(pslverr_w[d]), 32'h0);
        check({tag, "_prdata"},  prdata_w[d],       32'h0);
        check({tag, "_wr_en"},   32'(wr_en_w[d]),   32'h0);
        check({tag, "_wr_addr"}, 32'(wr_addr_w[d]), 32'h0);
        check({tag, "_wr_data"}, wr_data_w[d],      32'h0);
        check({tag, "_wr_be"},   32'(wr_be_w[d]),   32'h0);
        check({tag, "_rd_addr"}, 32'(rd_addr_w[d]), 32'hFF);
    endtask

    task automatic idle(input int d, input int n);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Runs one transfer starting at a negedge; returns at the negedge of the
    // cycle after RESP with psel still high, so a following call is back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [11:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic exp_err, input string tag);
        int          waits;
        int          wr_cnt;
        int          wr_k;
        int          rd_cnt;
        int          rd_k;
        bit          done;
        logic [7:0]  word;
        logic        exp_wr;
        logic [31:0] exp_rd;
        exp_t        e;
        waits  = (d == 1) ? 2 : 0;
        word   = addr[9:2];
        exp_wr = wr && !exp_err && (strb != 4'h0);
        exp_rd = exp_err ? 32'h0 : rf_model(word);
        sb_q.push_back('{is_read: !wr, rdata: exp_rd, err: exp_err});
        wr_cnt = 0; wr_k = 0; rd_cnt = 0; rd_k = 0; done = 1'b0;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        pstrb[d]   = strb;
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clk);
            penable[d] = 1'b1;
            if (wr_en_w[d] === 1'b1) begin
                wr_cnt++;
                wr_k = k;
                check({tag, "_wr_addr"}, 32'(wr_addr_w[d]), 32'(word));
                check({tag, "_wr_data"}, wr_data_w[d], data);
                check({tag, "_wr_be"},   32'(wr_be_w[d]), 32'(strb));
            end
            if (rd_addr_w[d] !== 8'hFF) begin
                rd_cnt++;
                rd_k = k;
                check({tag, "_rd_addr"}, 32'(rd_addr_w[d]), 32'(word));
            end
            if (pready_w[d] === 1'b1) begin
                done = 1'b1;
                check({tag, "_pready_cycle"}, 32'(k), 32'(2 + waits));
                e = sb_q.pop_front();
                check({tag, "_pslverr"}, 32'(pslverr_w[d]), 32'(e.err));
                if (e.is_read) begin
                    check({tag, "_prdata"}, prdata_w[d], e.rdata);
                end
            end else if (k >= 2) begin
                check({tag, "_pslverr_wait"}, 32'(pslverr_w[d]), 32'h0);
                if (!wr) begin
                    check({tag, "_prdata_wait"}, prdata_w[d], exp_rd);
                end
            end
        end
        if (!done) begin
            check({tag, "_pready_timeout"}, 32'h0, 32'h1);
            e = sb_q.pop_front();
        end
        check({tag, "_wr_pulses"}, 32'(wr_cnt), exp_wr ? 32'h1 : 32'h0);
        if (wr_cnt == 1) begin
            check({tag, "_wr_cycle"}, 32'(wr_k), 32'h1);
        end
        check({tag, "_rd_hits"}, 32'(rd_cnt), (!wr && !exp_err) ? 32'h1 : 32'h0);
        if (rd_cnt == 1) begin
            check({tag, "_rd_cycle"}, 32'(rd_k), 32'h1);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_values(0, "rst0");
        check_reset_values(1, "rst1");
        rst = 1'b0;
        idle(0, 2);

        xfer(0, 1'b1, 12'h020, 32'hA5A5_0F0F, 4'b0101, 1'b0, "wr_020");
        idle(0, 1);
        xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 1'b0, "rd_008");
        idle(0, 1);
        check("prdata_hold", prdata_w[0], 32'h1234_5678);

        xfer(0, 1'b1, 12'h006, 32'h1111_1111, 4'hF, 1'b1, "wr_misalign");
        idle(0, 1);
        xfer(0, 1'b1, 12'h040, 32'h2222_2222, 4'hF, 1'b1, "wr_range");
        idle(0, 1);
        xfer(0, 1'b1, 12'h420, 32'h3333_3333, 4'hF, 1'b1, "wr_upper");
        idle(0, 1);
        xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, 1'b1, "rd_range");
        xfer(0, 1'b0, 12'h038, 32'h0, 4'h0, 1'b0, "rd_max");
        xfer(0, 1'b0, 12'h03C, 32'h0, 4'h0, 1'b1, "rd_max_plus1");
        idle(0, 1);

        xfer(0, 1'b1, 12'h010, 32'h4444_4444, 4'h0, 1'b0, "wr_nostrb");
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, "rd_000_b2b");
        idle(0, 1);

        // Reset lands on the edge ending the CMD cycle of a write.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 12'h00C; pwdata[0] = 32'hCAFE_F00D; pstrb[0] = 4'hF;
        @(negedge clk);
        check("rstcmd_wr_en", 32'(wr_en_w[0]), 32'h1);
        rst = 1'b1;
        penable[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        psel[0] = 1'b0; penable[0] = 1'b0;
        check_reset_values(0, "rstcmd");
        @(negedge clk);
        check("rstcmd_no_pready", 32'(pready_w[0]), 32'h0);
        xfer(0, 1'b1, 12'h004, 32'h5A5A_A5A5, 4'b1100, 1'b0, "wr_after_rst");
        idle(0, 1);

        xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, 1'b0, "ws_rd_008");
        idle(1, 1);
        xfer(1, 1'b1, 12'h014, 32'h0BAD_CAFE, 4'b0011, 1'b0, "ws_wr_014");
        xfer(1, 1'b0, 12'h006, 32'h0, 4'h0, 1'b1, "ws_rd_misalign");
        idle(1, 2);

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
